// File: rtl/blk_move_pkg.sv
// Shared types for the block-move sequencer: FSM state encoding and pointer direction codes.
package blk_move_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/blk_move_seq_wait_timer.sv
// Loadable down-counter that flags when a memory access has waited LIMIT consecutive cycles.
module wait_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with LIMIT-1 on entry, so the LIMIT-th waiting cycle sees zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(LIMIT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/blk_move_seq.sv
// Block-move sequencer: copies count words using the A/B registers as source/destination pointers.
// Defining BLKMOV_FILL_EN adds a fill mode that writes a constant to B without reading.
module blk_move_seq
  import blk_move_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] src_ptr,
  input  logic [ADDR_W-1:0] dst_ptr,
  output logic              a_inc,
  output logic              a_dec,
  output logic              b_inc,
  output logic              b_dec,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef BLKMOV_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_val
`endif
);

  state_e            state_q, state_d, access_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              a_inc_q, a_inc_d, a_dec_q, a_dec_d;
  logic              b_inc_q, b_inc_d, b_dec_q, b_dec_d;
  logic              copy_d, step_d, tmr_expired;
`ifdef BLKMOV_FILL_EN
  logic              fill_q, fill_d;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef BLKMOV_FILL_EN
    fill_d = fill_q;
    if ((state_q == S_IDLE) && start) fill_d = fill;
    copy_d = !fill_d;
`else
    copy_d = 1'b1;
`endif
    // Fill mode never reads, so each word starts at the write.
    access_d = copy_d ? S_READ : S_WRITE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d = dir;
          rem_d = count;
          err_d = 1'b0;
`ifdef BLKMOV_FILL_EN
          if (fill) data_d = fill_val;
`endif
          state_d = (count == '0) ? S_DONE : access_d;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = S_WRITE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          state_d = S_STEP;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : access_d;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    step_d  = (state_d == S_STEP);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_d    = (state_d == S_READ);
    wr_d    = (state_d == S_WRITE);
    a_inc_d = step_d && copy_d && (dir_d == DIR_UP);
    a_dec_d = step_d && copy_d && (dir_d == DIR_DOWN);
    b_inc_d = step_d && (dir_d == DIR_UP);
    b_dec_d = step_d && (dir_d == DIR_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      rem_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      a_inc_q <= 1'b0;
      a_dec_q <= 1'b0;
      b_inc_q <= 1'b0;
      b_dec_q <= 1'b0;
`ifdef BLKMOV_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      a_inc_q <= a_inc_d;
      a_dec_q <= a_dec_d;
      b_inc_q <= b_inc_d;
      b_dec_q <= b_dec_d;
`ifdef BLKMOV_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  generate
    if (WAIT_LIMIT > 0) begin : g_timer
      wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (state_d != state_q),
        .en      ((state_q == S_READ) || (state_q == S_WRITE)),
        .expired (tmr_expired)
      );
    end else begin : g_no_timer
      assign tmr_expired = 1'b0;
    end
  endgenerate

  // Address follows the live register values, so a READ after STEP sees the updated pointer.
  assign mem_addr  = (state_q == S_READ)  ? src_ptr :
                     (state_q == S_WRITE) ? dst_ptr : '0;
  assign mem_wdata = data_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign a_inc     = a_inc_q;
  assign a_dec     = a_dec_q;
  assign b_inc     = b_inc_q;
  assign b_dec     = b_dec_q;

endmodule

// File: tb/tb_blk_move_seq.sv
// Scoreboard bench for blk_move_seq: random moves against a word-level reference of the copy.
module tb_blk_move_seq;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int WL = 4;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst, start, dir;
  logic [CW-1:0] count;
  logic [AW-1:0] src_ptr, dst_ptr, src_base, dst_base, src_off, dst_off;
  logic          a_inc, a_dec, b_inc, b_dec;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, mem_ready;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, err;
`ifdef BLKMOV_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_val;
`endif

  acc_t          exp_q[$];
  int            nvec = 0;
  int            nerr = 0;
  int            na_inc = 0, na_dec = 0, nb_inc = 0, nb_dec = 0, nrd = 0, nwr = 0;
  int            delay, age;
  logic [DW-1:0] salt;
  logic          hold_wr;
  logic [AW-1:0] hold_addr;

  always #5 clk = ~clk;

  assign src_ptr = src_base + src_off;
  assign dst_ptr = dst_base + dst_off;

  blk_move_seq #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .count(count),
    .src_ptr(src_ptr), .dst_ptr(dst_ptr),
    .a_inc(a_inc), .a_dec(a_dec), .b_inc(b_inc), .b_dec(b_dec),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
`ifdef BLKMOV_FILL_EN
    , .fill(fill), .fill_val(fill_val)
`endif
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory responder, A/B register model and scoreboard checker.
  always @(negedge clk) begin
    acc_t e;
    if (rst || done) begin
      src_off = '0;
      dst_off = '0;
    end
    if (rst) begin
      mem_ready = 1'b0;
      age = 0;
    end else begin
      if (a_inc) begin src_off = src_off + 16'd1; na_inc++; end
      if (a_dec) begin src_off = src_off - 16'd1; na_dec++; end
      if (b_inc) begin dst_off = dst_off + 16'd1; nb_inc++; end
      if (b_dec) begin dst_off = dst_off - 16'd1; nb_dec++; end
      if (mem_rd || mem_wr) begin
        chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (age > 0) chk("req_stable", {15'd0, mem_wr, mem_addr}, {15'd0, hold_wr, hold_addr});
        hold_wr   = mem_wr;
        hold_addr = mem_addr;
        if (mem_rd) nrd++;
        if (mem_wr) nwr++;
        mem_rdata = mem_val(mem_addr);
        mem_ready = (age >= delay);
        if (mem_ready) begin
          age = 0;
          chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("acc_kind", 32'(mem_wr), 32'(e.wr));
            chk("acc_addr", 32'(mem_addr), 32'(e.addr));
            if (mem_wr) chk("wr_data", 32'(mem_wdata), 32'(e.data));
          end
        end else begin
          age++;
        end
      end else begin
        mem_ready = 1'b0;
        age = 0;
      end
    end
  end

  task automatic run_move(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] n,
                          input logic dr, input int dly, input logic fl, input logic [DW-1:0] fv);
    int   ni, lat, exp_lat, per_word, exp_rd, exp_wr, a0, a1, b0, b1, r0, w0;
    logic timed;
    logic [AW-1:0] a, b;
    ni    = int'(n);
    salt  = DW'($urandom);
    delay = dly;
    src_base = s;
    dst_base = d;
    timed = (ni != 0) && (dly >= WL);
    if (!timed) begin
      for (int i = 0; i < ni; i++) begin
        a = dr ? s - AW'(i) : s + AW'(i);
        b = dr ? d - AW'(i) : d + AW'(i);
        if (!fl) exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
        exp_q.push_back('{wr: 1'b1, addr: b, data: (fl ? fv : mem_val(a))});
      end
    end
    per_word = fl ? (dly + 2) : (2 * (dly + 1) + 1);
    exp_lat  = (ni == 0) ? 1 : (timed ? 1 + WL : 1 + ni * per_word);
    exp_rd   = fl ? 0 : (timed ? WL : ni * (dly + 1));
    exp_wr   = !fl ? (timed ? 0 : ni * (dly + 1)) : (timed ? WL : ni * (dly + 1));
    a0 = na_inc; a1 = na_dec; b0 = nb_inc; b1 = nb_dec; r0 = nrd; w0 = nwr;
    dir = dr;
    count = n;
`ifdef BLKMOV_FILL_EN
    fill = fl;
    fill_val = fv;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < exp_lat + 40) begin
      tick();
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("err_flag", 32'(err), 32'(timed));
    chk("a_inc_count", 32'(na_inc - a0), 32'((!timed && !dr && !fl) ? ni : 0));
    chk("a_dec_count", 32'(na_dec - a1), 32'((!timed && dr && !fl) ? ni : 0));
    chk("b_inc_count", 32'(nb_inc - b0), 32'((!timed && !dr) ? ni : 0));
    chk("b_dec_count", 32'(nb_dec - b1), 32'((!timed && dr) ? ni : 0));
    chk("rd_cycles", 32'(nrd - r0), 32'(exp_rd));
    chk("wr_cycles", 32'(nwr - w0), 32'(exp_wr));
    tick();
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("move src=%h dst=%h n=%0d dir=%0d wait=%0d fill=%0d latency=%0d err=%0b",
             s, d, ni, dr, dly, fl, lat, err);
  endtask

  initial begin
    int a0, w0, guard;
    logic fl;
    rst = 1'b1; start = 1'b0; dir = 1'b0; count = '0;
    src_base = '0; dst_base = '0; delay = 0; salt = '0;
`ifdef BLKMOV_FILL_EN
    fill = 1'b0; fill_val = '0;
`endif
    repeat (3) tick();
    chk("reset_ctrl", {23'd0, busy, done, err, mem_rd, mem_wr, a_inc, a_dec, b_inc, b_dec}, 32'd0);
    chk("reset_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    tick();

    run_move(16'h0100, 16'h0200, 16'd3, 1'b0, 0, 1'b0, 16'h0);
    run_move(16'h0505, 16'h0A0A, 16'd2, 1'b1, 2, 1'b0, 16'h0);
    run_move(16'h1234, 16'h4321, 16'd0, 1'b0, 0, 1'b0, 16'h0);
    run_move(16'hFFFE, 16'h0001, 16'd4, 1'b0, 1, 1'b0, 16'h0);
    run_move(16'h0001, 16'hFFFF, 16'd3, 1'b1, 0, 1'b0, 16'h0);

    // Reset while the second word is being written.
    salt = DW'($urandom);
    delay = 0;
    src_base = 16'h0300;
    dst_base = 16'h0400;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: 16'h0300 + 16'(i), data: '0});
      exp_q.push_back('{wr: 1'b1, addr: 16'h0400 + 16'(i), data: mem_val(16'h0300 + 16'(i))});
    end
    a0 = na_inc; w0 = nwr;
    dir = 1'b0; count = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(mem_wr && (nwr - w0) == 2) && guard < 50) begin
      tick();
      guard++;
    end
    chk("reached_write2", 32'(mem_wr && (nwr - w0) == 2), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_abort", {29'd0, busy, mem_wr, mem_rd}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    chk("rst_no_step", 32'(na_inc - a0), 32'd1);
    chk("rst_idle", {30'd0, busy, done}, 32'd0);
    $display("move src=0300 dst=0400 n=3 reset during second write");

    run_move(16'h0700, 16'h0800, 16'd2, 1'b0, 1000, 1'b0, 16'h0);
    run_move(16'h0700, 16'h0800, 16'd0, 1'b0, 0, 1'b0, 16'h0);

    for (int t = 0; t < 24; t++) begin
`ifdef BLKMOV_FILL_EN
      fl = 1'($urandom_range(0, 1));
`else
      fl = 1'b0;
`endif
      run_move(AW'($urandom), AW'($urandom), CW'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), fl, DW'($urandom));
    end

`ifdef BLKMOV_FILL_EN
    run_move(16'h2222, 16'h0010, 16'd2, 1'b0, 0, 1'b1, 16'hBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
